mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single downstream memory request/response port between two requesters (one transaction in flight at a time).
- Master 0 is the MMU memory side (request_enable/req_* out, response_enable/resp_data in).
- Master 1 is a secondary bus master (boot loader / DMA).
- Sits between the MMU and the memory/cache controller; replays each master's one-cycle request pulse downstream and routes the response pulse back to the owner.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between masters; 1 = master 0 always wins simultaneous contention.
- TIMEOUT_CYCLES, 1024: wait-for-response limit (used only with ARB_TIMEOUT_EN); counter width = $clog2(TIMEOUT_CYCLES)+1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m0_request_enable  in  1  one-cycle request pulse from master 0 (MMU)
- m0_req_mode  in  1  MEMREQ_READ / MEMREQ_WRITE
- m0_req_addr  in  32  physical byte address
- m0_req_wdata  in  32  write data
- m0_req_wstrb  in  4  byte strobes
- m0_response_enable  out  1  one-cycle response pulse to master 0
- m0_resp_data  out  32  read data to master 0
- m1_request_enable, m1_req_mode, m1_req_addr, m1_req_wdata, m1_req_wstrb  in  1/1/32/32/4  same as m0 for master 1
- m1_response_enable  out  1  one-cycle response pulse to master 1
- m1_resp_data  out  32  read data to master 1
- request_enable  out  1  one-cycle request pulse downstream
- req_mode  out  1  downstream mode
- req_addr  out  32  downstream address
- req_wdata  out  32  downstream write data
- req_wstrb  out  4  downstream strobes
- response_enable  in  1  downstream response pulse
- resp_data  in  32  downstream read data
- overflow  out  1  sticky: a request pulse arrived while that master's slot was full
- bus_error  out  1  one-cycle pulse with a timed-out response (0 when ARB_TIMEOUT_EN is undefined)

Behaviour:
- Reset (async, rstn low): every output 0, both slots invalid, state IDLE, last_grant = 1 (so master 0 wins first), timeout counter 0. A transaction in flight is abandoned; a later response_enable in IDLE is ignored.
- Request slots: one per master, holding {mode, addr, wdata, wstrb}.
  - A pulse captures into the slot when the slot is invalid.
  - A pulse while the slot is valid is dropped and sets overflow (cleared only by reset).
  - A slot stays valid until its response pulse has been delivered.
- FSM states: IDLE, ISSUE, WAIT_RESP, RESPOND.
- IDLE: if any slot is valid and not yet issued, pick a winner, latch owner, load req_* from the owner's slot, and go to ISSUE.
  - Round-robin: the winner is the master other than last_grant when both are pending.
  - FIXED_PRIO=1: master 0 wins when both are pending.
  - last_grant is updated on grant.
  - A pulse captured this cycle is visible to arbitration next cycle, so minimum request-to-downstream latency is 2 cycles.
- ISSUE: request_enable = 1 for exactly one cycle, then WAIT_RESP. req_* hold their value until the next grant.
- WAIT_RESP: on response_enable, register resp_data into the owner's mN_resp_data, assert the owner's mN_response_enable next cycle, and go to RESPOND.
  - The non-owner's resp_data is unchanged.
  - response_enable in any other state is ignored.
- RESPOND: clear the response pulse, invalidate the owner's slot, go to IDLE. Response latency is 1 cycle after response_enable.
- Simultaneous pulses from both masters in one cycle: both captured; served in arbitration order back-to-back.
- A new pulse from a master on the cycle its slot is invalidated: captured (set wins over clear).
- The downstream port never sees two outstanding requests.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: WAIT_RESP counts cycles. When the count reaches TIMEOUT_CYCLES without response_enable:
  - deliver a response to the owner with data 32'h0 and a bus_error pulse in the same cycle;
  - then go through RESPOND to IDLE;
  - a late downstream response is ignored.
  - The counter clears on entry to WAIT_RESP.
- Undefined: no counter; WAIT_RESP waits indefinitely; bus_error is tied to 0.

Decomposition:
- Shared package (def.sv): MEMREQ_READ/MEMREQ_WRITE, arb_state_t enum {IDLE, ISSUE, WAIT_RESP, RESPOND}, arb_owner_t enum {OWNER_M0, OWNER_M1}.
- Add a memreq_slot_t packed struct {mode, addr, wdata, wstrb} to def.sv.
- One sub-module is natural: mem_req_slot (single-entry capture buffer with valid/overflow logic), instantiated twice.

Test Plan:
- m0 read to addr 32'h0000_1000, memory replies 32'hDEADBEEF 3 cycles after request_enable → request_enable 2 cycles after the m0 pulse; m0_response_enable is a one-cycle pulse with data 32'hDEADBEEF; m1 outputs stay 0.
- m0 and m1 pulse in the same cycle (read 0x100 / write 0x200 wdata 0x55 wstrb 4'b0001), FIXED_PRIO=0 after reset → m0 request served first, then m1; second pulse on the m0 channel is served after m1; no overflow.
- FIXED_PRIO=1, m1 pending, m0 pulses repeatedly after each m0 response → m0 keeps winning while pending; m1 is served as soon as m0's slot is empty.
- m1 pulses twice before its first response → second pulse dropped; overflow = 1 and stays set; only one m1 downstream request seen.
- rstn pulled low during WAIT_RESP, released, then a stray response_enable arrives → all outputs 0; no mN_response_enable; next m0 request is handled normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no downstream response → after 16 wait cycles, owner gets response data 0 with bus_error pulse; a late response_enable at cycle 20 is ignored.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared request encodings, FSM/owner enums and the slot record
// for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} arb_state_t;

  typedef enum logic {OWNER_M0, OWNER_M1} arb_owner_t;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memreq_slot_t;

endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: single-entry request capture buffer; a pulse into a full slot is
// dropped and sets a sticky overflow flag.
module mem_req_slot
  import mem_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_pulse,
  input  logic         i_clear,
  input  memreq_slot_t i_req,
  output logic         o_valid,
  output logic         o_overflow,
  output memreq_slot_t o_req
);

  logic         r_valid;
  logic         r_overflow;
  memreq_slot_t r_req;
  logic         w_capture;

  // A pulse on the clearing cycle refills the slot rather than overflowing it.
  assign w_capture = i_pulse && (!r_valid || i_clear);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_req      <= '0;
    end else begin
      r_valid    <= w_capture || (r_valid && !i_clear);
      r_overflow <= r_overflow || (i_pulse && !w_capture);
      if (w_capture) r_req <= i_req;
    end
  end

  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;
  assign o_req      = r_req;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between two masters, one
// transaction in flight. Optional response timeout via macro ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_request_enable,
  input  logic        m0_req_mode,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  input  logic [3:0]  m0_req_wstrb,
  output logic        m0_response_enable,
  output logic [31:0] m0_resp_data,
  input  logic        m1_request_enable,
  input  logic        m1_req_mode,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_wstrb,
  output logic        m1_response_enable,
  output logic [31:0] m1_resp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        overflow,
  output logic        bus_error
);

  arb_state_t   r_state;
  arb_owner_t   r_owner, r_last, w_win;
  memreq_slot_t r_req, w_s0, w_s1;
  logic         r_rsp0, r_rsp1, r_berr;
  logic [31:0]  r_d0, r_d1, w_rdata;
  logic         w_v0, w_v1, w_o0, w_o1, w_tmo, w_done;

  mem_req_slot u_slot0 (
    .clk       (clk),
    .rstn      (rstn),
    .i_pulse   (m0_request_enable),
    .i_clear   (r_state == RESPOND && r_owner == OWNER_M0),
    .i_req     ({m0_req_mode, m0_req_addr, m0_req_wdata, m0_req_wstrb}),
    .o_valid   (w_v0),
    .o_overflow(w_o0),
    .o_req     (w_s0)
  );

  mem_req_slot u_slot1 (
    .clk       (clk),
    .rstn      (rstn),
    .i_pulse   (m1_request_enable),
    .i_clear   (r_state == RESPOND && r_owner == OWNER_M1),
    .i_req     ({m1_req_mode, m1_req_addr, m1_req_wdata, m1_req_wstrb}),
    .o_valid   (w_v1),
    .o_overflow(w_o1),
    .o_req     (w_s1)
  );

  always_comb begin
    w_win = OWNER_M0;
    if (w_v1 && (!w_v0 || (FIXED_PRIO == 0 && r_last == OWNER_M0))) w_win = OWNER_M1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else       r_cnt <= (r_state == WAIT_RESP) ? r_cnt + 1'b1 : '0;
  end
  assign w_tmo = r_state == WAIT_RESP && !response_enable && r_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign w_tmo = TIMEOUT_CYCLES < 0;
`endif

  assign w_done  = response_enable || w_tmo;
  assign w_rdata = response_enable ? resp_data : 32'h0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_owner <= OWNER_M0;
      r_last  <= OWNER_M1;
      r_req   <= '0;
      r_rsp0  <= 1'b0;
      r_rsp1  <= 1'b0;
      r_d0    <= 32'h0;
      r_d1    <= 32'h0;
      r_berr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_v0 || w_v1) begin
          r_state <= ISSUE;
          r_owner <= w_win;
          r_last  <= w_win;
          r_req   <= (w_win == OWNER_M0) ? w_s0 : w_s1;
        end
        ISSUE: r_state <= WAIT_RESP;
        WAIT_RESP: if (w_done) begin
          r_state <= RESPOND;
          r_berr  <= w_tmo;
          if (r_owner == OWNER_M0) begin
            r_rsp0 <= 1'b1;
            r_d0   <= w_rdata;
          end else begin
            r_rsp1 <= 1'b1;
            r_d1   <= w_rdata;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rsp0  <= 1'b0;
          r_rsp1  <= 1'b0;
          r_berr  <= 1'b0;
        end
      endcase
    end
  end

  assign request_enable     = r_state == ISSUE;
  assign req_mode           = r_req.mode;
  assign req_addr           = r_req.addr;
  assign req_wdata          = r_req.wdata;
  assign req_wstrb          = r_req.wstrb;
  assign m0_response_enable = r_rsp0;
  assign m0_resp_data       = r_d0;
  assign m1_response_enable = r_rsp1;
  assign m1_resp_data       = r_d1;
  assign overflow           = w_o0 || w_o1;
  assign bus_error          = r_berr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven cycle vectors plus directed sequences for overflow,
// reset in flight, fixed priority and (with ARB_TIMEOUT_EN) the response timeout.
module tb_mem_arbiter;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        p0 = 0, p1 = 0, rv = 0;
  logic [31:0] a0 = 0, a1 = 0, rd = 0;
  logic        r0, r1, req, mode, ovf, berr;
  logic [31:0] d0, d1, addr, wd;
  logic [3:0]  ws;
  logic        f_r0, f_r1, f_req, f_mode, f_ovf, f_berr;
  logic [31:0] f_d0, f_d1, f_addr, f_wd;
  logic [3:0]  f_ws;
  int          pass_n = 0, total_n = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(16)) u_rr (
    .clk(clk), .rstn(rstn),
    .m0_request_enable(p0), .m0_req_mode(1'b0), .m0_req_addr(a0), .m0_req_wdata(32'h0), .m0_req_wstrb(4'h0),
    .m0_response_enable(r0), .m0_resp_data(d0),
    .m1_request_enable(p1), .m1_req_mode(1'b1), .m1_req_addr(a1), .m1_req_wdata(32'h55), .m1_req_wstrb(4'h1),
    .m1_response_enable(r1), .m1_resp_data(d1),
    .request_enable(req), .req_mode(mode), .req_addr(addr), .req_wdata(wd), .req_wstrb(ws),
    .response_enable(rv), .resp_data(rd), .overflow(ovf), .bus_error(berr)
  );

  mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(16)) u_fp (
    .clk(clk), .rstn(rstn),
    .m0_request_enable(p0), .m0_req_mode(1'b0), .m0_req_addr(a0), .m0_req_wdata(32'h0), .m0_req_wstrb(4'h0),
    .m0_response_enable(f_r0), .m0_resp_data(f_d0),
    .m1_request_enable(p1), .m1_req_mode(1'b1), .m1_req_addr(a1), .m1_req_wdata(32'h55), .m1_req_wstrb(4'h1),
    .m1_response_enable(f_r1), .m1_resp_data(f_d1),
    .request_enable(f_req), .req_mode(f_mode), .req_addr(f_addr), .req_wdata(f_wd), .req_wstrb(f_ws),
    .response_enable(rv), .resp_data(rd), .overflow(f_ovf), .bus_error(f_berr)
  );

  typedef struct {
    logic rst, p0; logic [31:0] a0; logic p1; logic [31:0] a1; logic rv; logic [31:0] rd;
    logic e_req, e_own; logic [31:0] e_addr; logic e_r0; logic [31:0] e_d0;
    logic e_r1; logic [31:0] e_d1; logic e_ovf;
  } vec_t;

  vec_t        tv[$];
  logic [159:0] act, expv;
  logic        ok, got_rsp, got_req;
  logic [31:0] a;
  logic [31:0] fp_exp [4] = '{32'h600, 32'h601, 32'h602, 32'h700};
  int          n;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    total_n++;
    if (got === want) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic cyc();
    @(negedge clk);
    p0 = 0; p1 = 0; rv = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0; p0 = 0; p1 = 0; rv = 0;
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic wait_req(input bit fp, output logic found, output logic [31:0] ad);
    found = 0;
    ad = 32'h0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (fp ? f_req : req) begin
        found = 1;
        ad = fp ? f_addr : addr;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // rst p0 a0 p1 a1 rv rd | req own addr r0 d0 r1 d1 ovf
    tv.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1000, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h1000, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 1, 32'hDEADBEEF, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 32'hDEADBEEF, 0, 0, 0});
    tv.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 1, 32'h11111111, 0, 0, 32'h100, 0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h11111111, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h11111111, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h200, 0, 32'h11111111, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 1, 32'h22222222, 0, 1, 32'h200, 0, 32'h11111111, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 32'h11111111, 1, 32'h22222222, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 32'h11111111, 0, 32'h22222222, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h300, 0, 32'h11111111, 0, 32'h22222222, 0});
    tv.push_back('{0, 0, 0, 0, 0, 1, 32'h33333333, 0, 0, 32'h300, 0, 32'h11111111, 0, 32'h22222222, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300, 1, 32'h33333333, 0, 32'h22222222, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 32'h33333333, 0, 32'h22222222, 0});

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rstn = !tv[i].rst;
      p0 = tv[i].p0; a0 = tv[i].a0; p1 = tv[i].p1; a1 = tv[i].a1; rv = tv[i].rv; rd = tv[i].rd;
      #1;
      act  = {req, mode, addr, wd, ws, r0, d0, r1, d1, ovf, berr};
      expv = {tv[i].e_req, tv[i].e_own, tv[i].e_addr, tv[i].e_own ? 32'h55 : 32'h0,
              tv[i].e_own ? 4'h1 : 4'h0, tv[i].e_r0, tv[i].e_d0, tv[i].e_r1, tv[i].e_d1,
              tv[i].e_ovf, 1'b0};
      check($sformatf("row%0d", i), act, expv);
    end

    // second m1 pulse while its slot is full is dropped
    cyc();
    p1 = 1; a1 = 32'h400;
    cyc();
    p1 = 1; a1 = 32'h500;
    cyc();
    check("ovf_issue", {ovf, req, addr}, {1'b1, 1'b1, 32'h400});
    cyc();
    rv = 1; rd = 32'h44;
    got_rsp = 0; n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      got_rsp |= r1;
      n += int'(req);
    end
    check("ovf_resp", {got_rsp, d1}, {1'b1, 32'h44});
    check("ovf_one_req", n, 0);
    check("ovf_sticky", ovf, 1);

    // reset while waiting for a response, then a stray response
    cyc();
    p0 = 1; a0 = 32'h800;
    wait_req(0, ok, a);
    check("rst_issue", {ok, a}, {1'b1, 32'h800});
    cyc();
    rstn = 0;
    #1;
    check("rst_outs", {req, mode, addr, wd, ws, r0, d0, r1, d1, ovf, berr}, 0);
    cyc();
    rstn = 1;
    cyc();
    rv = 1; rd = 32'h99;
    got_rsp = 0; got_req = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      got_rsp |= r0 | r1;
      got_req |= req;
    end
    check("rst_stray", {got_rsp, got_req, d0, d1}, 0);
    cyc();
    p0 = 1; a0 = 32'h900;
    wait_req(0, ok, a);
    check("rst_next_issue", {ok, a}, {1'b1, 32'h900});
    cyc();
    rv = 1; rd = 32'hA5;
    cyc();
    check("rst_next_resp", {r0, d0, r1}, {1'b1, 32'hA5, 1'b0});

    // fixed priority: m0 keeps winning while it refills its slot
    do_reset();
    cyc();
    p0 = 1; a0 = 32'h600; p1 = 1; a1 = 32'h700;
    for (int r = 0; r < 4; r++) begin
      wait_req(1, ok, a);
      check($sformatf("fp_order%0d", r), {ok, a}, {1'b1, fp_exp[r]});
      cyc();
      rv = 1; rd = r;
      cyc();
      check($sformatf("fp_owner%0d", r), {f_r0, f_r1}, (r < 3) ? 2'b10 : 2'b01);
      if (r < 2) begin
        p0 = 1; a0 = 32'h601 + r;
      end
    end
    check("fp_no_ovf", f_ovf, 0);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    cyc();
    p0 = 1; a0 = 32'hA00;
    wait_req(0, ok, a);
    cyc();
    rv = 1; rd = 32'h5A;
    cyc();
    cyc();
    p0 = 1; a0 = 32'hB00;
    wait_req(0, ok, a);
    check("tmo_issue", {ok, a, d0}, {1'b1, 32'hB00, 32'h5A});
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (r0) break;
      n++;
    end
    check("tmo_wait", n, 16);
    check("tmo_resp", {r0, d0, berr}, {1'b1, 32'h0, 1'b1});
    cyc();
    check("tmo_berr_clear", {r0, berr}, 0);
    cyc();
    cyc();
    rv = 1; rd = 32'h77;
    got_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      got_rsp |= r0 | r1 | berr;
    end
    check("tmo_late_ignored", {got_rsp, d0}, 0);
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
